// File: rtl/weight_bram_sequencer_if.sv
// weight_bram_sequencer_if: bundles the load handshake, BRAM port and weight stream of the sequencer.
interface weight_bram_sequencer_if #(
   parameter int DW = 16,
   parameter int AW = 5
);
   logic          start;
   logic          ld_valid;
   logic [DW-1:0] ld_data;
   logic          ld_ready;
   logic          loaded;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_di;
   logic          bram_en;
   logic          bram_we;
   logic [DW-1:0] bram_do;
   logic          w_valid;
   logic [DW-1:0] w_data;
   logic [AW-1:0] w_idx;
   logic          busy;
   logic          done;
   modport slave (
      input  start, ld_valid, ld_data, bram_do,
      output ld_ready, loaded, bram_addr, bram_di, bram_en, bram_we, w_valid, w_data, w_idx, busy, done
   );
   modport master (
      output start, ld_valid, ld_data, bram_do,
      input  ld_ready, loaded, bram_addr, bram_di, bram_en, bram_we, w_valid, w_data, w_idx, busy, done
   );
endinterface

// File: rtl/weight_bram_sequencer.sv
// weight_bram_sequencer: loads DEPTH weights into a falling-edge BRAM and replays them as a fixed-latency burst.
module weight_bram_sequencer #(
   parameter int DW    = 16,
   parameter int AW    = 5,
   parameter int DEPTH = 28
) (
   input logic                            clk_i,
   input logic                            rst_n_i,
   weight_bram_sequencer_if.slave         bus
);
   typedef enum logic [1:0] {IDLE, LOAD, READ} state_t;
   state_t        state_q;
   logic [AW-1:0] cnt_q;
   logic          w_valid_q;
   logic [DW-1:0] w_data_q;
   logic [AW-1:0] w_idx_q;
   logic          done_q;
   logic          loaded_q;
   logic          wr;
   logic          rd;
   logic          last;
   assign wr   = state_q == LOAD && bus.ld_valid;
   assign rd   = state_q == READ;
   assign last = cnt_q == AW'(DEPTH - 1);
   // BRAM samples these on the falling edge, so they are driven within the same cycle
   assign bus.bram_en   = wr || rd;
   assign bus.bram_we   = wr;
   assign bus.bram_addr = (wr || rd) ? cnt_q : '0;
   assign bus.bram_di   = wr ? bus.ld_data : '0;
   assign bus.ld_ready  = state_q == LOAD;
   assign bus.w_valid   = w_valid_q;
   assign bus.w_data    = w_data_q;
   assign bus.w_idx     = w_idx_q;
   assign bus.done      = done_q;
   assign bus.loaded    = loaded_q;
   assign bus.busy      = state_q != IDLE || w_valid_q;
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         w_valid_q <= 1'b0;
         w_data_q  <= '0;
         w_idx_q   <= '0;
         done_q    <= 1'b0;
         loaded_q  <= 1'b0;
      end else begin
         w_valid_q <= 1'b0;
         done_q    <= 1'b0;
         loaded_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_q <= READ;
                  cnt_q   <= '0;
               end else if (bus.ld_valid) begin
                  state_q <= LOAD;
                  cnt_q   <= '0;
               end
            end
            LOAD: begin
               if (bus.ld_valid) begin
                  if (last) begin
                     state_q  <= IDLE;
                     cnt_q    <= '0;
                     loaded_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + AW'(1);
                  end
               end
            end
            READ: begin
               w_valid_q <= 1'b1;
               w_data_q  <= bus.bram_do;
               w_idx_q   <= cnt_q;
               if (last) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + AW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
